// File: rtl/itch_msg_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : itch_msg_framer_pkg
// Description : Shared types and constants for the ITCH message framer.
//               Holds the framer state encoding, the default maximum
//               message length and the default end-of-frame idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
package itch_msg_framer_pkg;

    // Largest legal ITCH message length in bytes.
    localparam int ITCH_MAX_MSG_LEN = 64;

    // Consecutive idle cycles on the byte strobe that close a frame.
    localparam int ITCH_FRAME_GAP   = 4;

    // Width of the per-message remaining/index counters.
    localparam int ITCH_IDX_W       = 6;

    typedef enum logic [1:0] {
        LEN_HI  = 2'd0,
        LEN_LO  = 2'd1,
        PAYLOAD = 2'd2,
        DRAIN   = 2'd3
    } itchFramerStateType;

endpackage
`default_nettype wire

// File: rtl/frame_gap_detect.sv
`default_nettype none
// ============================================================================
// Module      : frame_gap_detect
// Description : Infers frame boundaries on a byte stream from an idle gap on
//               the valid strobe. A 4-bit counter clears on every valid
//               byte, counts idle cycles and saturates at GAP_CYCLES.
//               frameEndOut pulses for one cycle: the idle cycle on which
//               the counter steps onto GAP_CYCLES.
// Ports       : clkIn       - clock
//               rstNIn      - asynchronous active-low reset
//               validIn     - byte strobe of the monitored stream
//               frameEndOut - one-cycle frame-end pulse
// Revision    : 1.0 - initial release
// ============================================================================
module frame_gap_detect
    import itch_msg_framer_pkg::*;
#(
    parameter int GAP_CYCLES = ITCH_FRAME_GAP
) (
    input  logic clkIn,
    input  logic rstNIn,
    input  logic validIn,
    output logic frameEndOut
);

    localparam logic [3:0] GAP_C      = 4'(GAP_CYCLES);
    localparam logic [3:0] GAP_LAST_C = 4'(GAP_CYCLES - 1);

    logic [3:0] gap_q;
    logic [3:0] gap_d;

    always_comb begin
        gap_d = gap_q;
        if (validIn) begin
            gap_d = 4'd0;
        end else if (gap_q != GAP_C) begin
            gap_d = gap_q + 4'd1;
        end
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            gap_q <= 4'd0;
        end else begin
            gap_q <= gap_d;
        end
    end

    // Fires only on the transition into the saturated value, so a long idle
    // period produces a single pulse.
    assign frameEndOut = !validIn && (gap_q == GAP_LAST_C);

endmodule
`default_nettype wire

// File: rtl/itch_msg_framer.sv
`default_nettype none
// ============================================================================
// Module      : itch_msg_framer
// Description : Splits the ITCH byte stream following the MoldUDP64 header
//               into messages. Each block is a 2-byte big-endian length
//               followed by that many payload bytes. Payload bytes are
//               re-emitted one cycle later with SOP/EOP, message type, byte
//               index, loss qualifier and error pulses.
// Ports       : clkIn           - clock (parser domain)
//               rstNIn          - asynchronous active-low reset
//               itchDataValidIn - input byte strobe
//               itchDataIn      - input byte
//               packetLostIn    - sequence-gap pulse for the current frame
//               msgValidOut     - payload byte valid
//               msgDataOut      - payload byte
//               msgSopOut       - first byte of a message
//               msgEopOut       - last byte of a message
//               msgTypeOut      - message type, held from SOP to next SOP
//               msgByteIdxOut   - byte index within the message
//               msgLostOut      - frame follows a sequence gap
//               truncErrOut     - frame ended inside a length or payload
//               lenErrOut       - length prefix above MAX_MSG_LEN
//               msgCntOut       - completed message count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module itch_msg_framer
    import itch_msg_framer_pkg::*;
#(
    parameter int MAX_MSG_LEN = ITCH_MAX_MSG_LEN,
    parameter int GAP_CYCLES  = ITCH_FRAME_GAP
) (
    input  logic        clkIn,
    input  logic        rstNIn,
    input  logic        itchDataValidIn,
    input  logic [7:0]  itchDataIn,
    input  logic        packetLostIn,
    output logic        msgValidOut,
    output logic [7:0]  msgDataOut,
    output logic        msgSopOut,
    output logic        msgEopOut,
    output logic [7:0]  msgTypeOut,
    output logic [5:0]  msgByteIdxOut,
    output logic        msgLostOut,
    output logic        truncErrOut,
    output logic        lenErrOut,
    output logic [31:0] msgCntOut
);

    localparam logic [15:0] MAX_LEN_C = 16'(MAX_MSG_LEN);

    itchFramerStateType    state_q, state_d;
    logic [7:0]            lenHi_q, lenHi_d;
    logic [ITCH_IDX_W-1:0] rem_q, rem_d;
    logic [ITCH_IDX_W-1:0] idx_q, idx_d;
    logic                  lost_q, lost_d;

    logic        valid_q,   valid_d;
    logic [7:0]  data_q,    data_d;
    logic        sop_q,     sop_d;
    logic        eop_q,     eop_d;
    logic [7:0]  type_q,    type_d;
    logic [5:0]  byteIdx_q, byteIdx_d;
    logic        msgLost_q, msgLost_d;
    logic        trunc_q,   trunc_d;
    logic        lenErr_q,  lenErr_d;
    logic [31:0] cnt_q,     cnt_d;

    logic        frameEnd;
    logic [15:0] lenWord;

    frame_gap_detect #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap (
        .clkIn       (clkIn),
        .rstNIn      (rstNIn),
        .validIn     (itchDataValidIn),
        .frameEndOut (frameEnd)
    );

    assign lenWord = {lenHi_q, itchDataIn};

    always_comb begin
        state_d   = state_q;
        lenHi_d   = lenHi_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        lost_d    = lost_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        type_d    = type_q;
        byteIdx_d = byteIdx_q;
        trunc_d   = 1'b0;
        lenErr_d  = 1'b0;
        cnt_d     = cnt_q;

        // frameEnd only fires while the strobe is low, so it never competes
        // with byte processing below.
        if (frameEnd) begin
            if (state_q == LEN_LO || state_q == PAYLOAD) begin
                trunc_d = 1'b1;
            end
            state_d = LEN_HI;
            lost_d  = 1'b0;
        end

        // A loss pulse coincident with frame end belongs to the next frame.
        if (packetLostIn) begin
            lost_d = 1'b1;
        end

        if (itchDataValidIn) begin
            case (state_q)
                LEN_HI: begin
                    lenHi_d = itchDataIn;
                    state_d = LEN_LO;
                end
                LEN_LO: begin
                    if (lenWord == 16'd0) begin
                        state_d = LEN_HI;
                    end else if (lenWord > MAX_LEN_C) begin
                        lenErr_d = 1'b1;
                        state_d  = DRAIN;
                    end else begin
                        // A length equal to 2**ITCH_IDX_W loads as 0; the
                        // down-counter wraps and still reaches 1 on the
                        // final byte.
                        rem_d   = lenWord[ITCH_IDX_W-1:0];
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    valid_d   = 1'b1;
                    data_d    = itchDataIn;
                    byteIdx_d = idx_q;
                    if (idx_q == '0) begin
                        sop_d  = 1'b1;
                        type_d = itchDataIn;
                    end
                    if (rem_q == ITCH_IDX_W'(1)) begin
                        eop_d   = 1'b1;
                        cnt_d   = cnt_q + 32'd1;
                        state_d = LEN_HI;
                    end
                    rem_d = rem_q - ITCH_IDX_W'(1);
                    idx_d = idx_q + ITCH_IDX_W'(1);
                end
                default: begin
                    // DRAIN: discard until the gap closes the frame.
                end
            endcase
        end

        msgLost_d = lost_q;
    end

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            state_q   <= LEN_HI;
            lenHi_q   <= 8'd0;
            rem_q     <= '0;
            idx_q     <= '0;
            lost_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 8'd0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            type_q    <= 8'd0;
            byteIdx_q <= 6'd0;
            msgLost_q <= 1'b0;
            trunc_q   <= 1'b0;
            lenErr_q  <= 1'b0;
            cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            lenHi_q   <= lenHi_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            lost_q    <= lost_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            type_q    <= type_d;
            byteIdx_q <= byteIdx_d;
            msgLost_q <= msgLost_d;
            trunc_q   <= trunc_d;
            lenErr_q  <= lenErr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign msgValidOut   = valid_q;
    assign msgDataOut    = data_q;
    assign msgSopOut     = sop_q;
    assign msgEopOut     = eop_q;
    assign msgTypeOut    = type_q;
    assign msgByteIdxOut = byteIdx_q;
    assign msgLostOut    = msgLost_q;
    assign truncErrOut   = trunc_q;
    assign lenErrOut     = lenErr_q;
    assign msgCntOut     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_itch_msg_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_itch_msg_framer
// Description : Directed self-checking bench for itch_msg_framer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itch_msg_framer;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic [7:0]  inData;
    logic        inLost;
    logic        msgValidOut;
    logic [7:0]  msgDataOut;
    logic        msgSopOut;
    logic        msgEopOut;
    logic [7:0]  msgTypeOut;
    logic [5:0]  msgByteIdxOut;
    logic        msgLostOut;
    logic        truncErrOut;
    logic        lenErrOut;
    logic [31:0] msgCntOut;

    int passCnt  = 0;
    int totalCnt = 0;

    itch_msg_framer dut (
        .clkIn           (clk),
        .rstNIn          (rstN),
        .itchDataValidIn (inValid),
        .itchDataIn      (inData),
        .packetLostIn    (inLost),
        .msgValidOut     (msgValidOut),
        .msgDataOut      (msgDataOut),
        .msgSopOut       (msgSopOut),
        .msgEopOut       (msgEopOut),
        .msgTypeOut      (msgTypeOut),
        .msgByteIdxOut   (msgByteIdxOut),
        .msgLostOut      (msgLostOut),
        .truncErrOut     (truncErrOut),
        .lenErrOut       (lenErrOut),
        .msgCntOut       (msgCntOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drive one cycle of input; outputs for that byte are sampled 1 ns
    // after the capturing edge.
    task automatic step(input logic v, input logic [7:0] d, input logic pl);
        inValid = v;
        inData  = d;
        inLost  = pl;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inData  = 8'h00;
        inLost  = 1'b0;
    endtask

    // Compare {valid, data (when valid), sop, eop, truncErr, lenErr}.
    task automatic beat(input string tag, input logic v, input logic [7:0] d,
                        input logic sop, input logic eop,
                        input logic tr, input logic le);
        chk(tag,
            {18'd0, msgValidOut, (msgValidOut ? msgDataOut : 8'h00),
             msgSopOut, msgEopOut, truncErrOut, lenErrOut},
            {18'd0, v, (v ? d : 8'h00), sop, eop, tr, le});
    endtask

    task automatic sendChk(input string tag, input logic [7:0] d, input logic v,
                           input logic sop, input logic eop);
        step(1'b1, d, 1'b0);
        beat(tag, v, d, sop, eop, 1'b0, 1'b0);
    endtask

    // n idle cycles, expecting silence except a truncation pulse on the
    // truncAt-th idle cycle (0 = never).
    task automatic idles(input string tag, input int n, input int truncAt);
        for (int i = 1; i <= n; i++) begin
            step(1'b0, 8'h00, 1'b0);
            beat(tag, 1'b0, 8'h00, 1'b0, 1'b0, (i == truncAt), 1'b0);
        end
    endtask

    initial begin
        rstN    = 1'b0;
        inValid = 1'b0;
        inData  = 8'h00;
        inLost  = 1'b0;
        #12;
        chk("rst_outputs",
            {msgValidOut, msgDataOut, msgSopOut, msgEopOut, msgTypeOut,
             msgByteIdxOut, msgLostOut, truncErrOut, lenErrOut},
            32'd0);
        chk("rst_cnt", msgCntOut, 32'd0);
        rstN = 1'b1;
        idles("idle0", 5, 0);

        // Two back-to-back messages.
        sendChk("m1_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("m1_ll", 8'h03, 1'b0, 1'b0, 1'b0);
        sendChk("m1_b0", 8'h41, 1'b1, 1'b1, 1'b0);
        chk("m1_type", {24'd0, msgTypeOut}, 32'h41);
        chk("m1_idx0", {26'd0, msgByteIdxOut}, 32'd0);
        sendChk("m1_b1", 8'h10, 1'b1, 1'b0, 1'b0);
        chk("m1_idx1", {26'd0, msgByteIdxOut}, 32'd1);
        sendChk("m1_b2", 8'h20, 1'b1, 1'b0, 1'b1);
        chk("m1_idx2", {26'd0, msgByteIdxOut}, 32'd2);
        chk("m1_type_hold", {24'd0, msgTypeOut}, 32'h41);
        chk("m1_cnt", msgCntOut, 32'd1);
        sendChk("m2_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("m2_ll", 8'h02, 1'b0, 1'b0, 1'b0);
        sendChk("m2_b0", 8'h45, 1'b1, 1'b1, 1'b0);
        chk("m2_type", {24'd0, msgTypeOut}, 32'h45);
        sendChk("m2_b1", 8'h99, 1'b1, 1'b0, 1'b1);
        idles("m2_gap", 5, 0);
        chk("m2_cnt", msgCntOut, 32'd2);

        // Truncation inside the payload.
        sendChk("tr_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("tr_ll", 8'h05, 1'b0, 1'b0, 1'b0);
        sendChk("tr_b0", 8'h41, 1'b1, 1'b1, 1'b0);
        sendChk("tr_b1", 8'h01, 1'b1, 1'b0, 1'b0);
        sendChk("tr_b2", 8'h02, 1'b1, 1'b0, 1'b0);
        idles("tr_gap", 6, 4);
        chk("tr_cnt", msgCntOut, 32'd2);
        sendChk("l1_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("l1_ll", 8'h01, 1'b0, 1'b0, 1'b0);
        sendChk("l1_b0", 8'h53, 1'b1, 1'b1, 1'b1);
        chk("l1_cnt", msgCntOut, 32'd3);
        idles("l1_gap", 4, 0);

        // Oversize length prefix (0x0100 > 64).
        sendChk("ov_lh", 8'h01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        beat("ov_lenerr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            sendChk("ov_drain", 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        end
        idles("ov_gap", 5, 0);
        sendChk("ov2_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("ov2_ll", 8'h01, 1'b0, 1'b0, 1'b0);
        sendChk("ov2_b0", 8'h55, 1'b1, 1'b1, 1'b1);
        chk("ov2_cnt", msgCntOut, 32'd4);
        idles("ov2_gap", 4, 0);

        // Boundary: length exactly 64 is legal, 65 is not.
        sendChk("mx_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("mx_ll", 8'h40, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            sendChk("mx_b", 8'(i), 1'b1, (i == 0), (i == 63));
        end
        chk("mx_idx63", {26'd0, msgByteIdxOut}, 32'd63);
        chk("mx_cnt", msgCntOut, 32'd5);
        sendChk("mx1_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h41, 1'b0);
        beat("mx1_lenerr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idles("mx1_gap", 4, 0);

        // Zero-length block and a short bubble inside a message.
        sendChk("z_lh0", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("z_ll0", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("z_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("z_ll", 8'h02, 1'b0, 1'b0, 1'b0);
        sendChk("z_b0", 8'h41, 1'b1, 1'b1, 1'b0);
        idles("z_bubble", 2, 0);
        sendChk("z_b1", 8'h42, 1'b1, 1'b0, 1'b1);
        chk("z_cnt", msgCntOut, 32'd6);
        idles("z_gap", 5, 0);

        // Loss flag.
        step(1'b0, 8'h00, 1'b1);
        sendChk("ls_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("ls_ll", 8'h01, 1'b0, 1'b0, 1'b0);
        sendChk("ls_b0", 8'h41, 1'b1, 1'b1, 1'b1);
        chk("ls_lost41", {31'd0, msgLostOut}, 32'd1);
        idles("ls_gap", 4, 0);
        sendChk("ls2_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("ls2_ll", 8'h01, 1'b0, 1'b0, 1'b0);
        sendChk("ls2_b0", 8'h42, 1'b1, 1'b1, 1'b1);
        chk("ls_lost42", {31'd0, msgLostOut}, 32'd0);
        idles("ls3_gap", 3, 0);
        step(1'b0, 8'h00, 1'b1);                // pulse on the frame-end cycle
        sendChk("ls3_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("ls3_ll", 8'h01, 1'b0, 1'b0, 1'b0);
        sendChk("ls3_b0", 8'h43, 1'b1, 1'b1, 1'b1);
        chk("ls_lost_coinc", {31'd0, msgLostOut}, 32'd1);
        idles("ls4_gap", 4, 0);
        sendChk("ls4_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("ls4_ll", 8'h01, 1'b0, 1'b0, 1'b0);
        sendChk("ls4_b0", 8'h46, 1'b1, 1'b1, 1'b1);
        chk("ls_lost_clr", {31'd0, msgLostOut}, 32'd0);
        chk("ls_cnt", msgCntOut, 32'd10);

        // Asynchronous reset in the middle of a payload.
        sendChk("r_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("r_ll", 8'h03, 1'b0, 1'b0, 1'b0);
        sendChk("r_b0", 8'h47, 1'b1, 1'b1, 1'b0);
        rstN = 1'b0;
        #1;
        chk("r_async_outputs",
            {msgValidOut, msgDataOut, msgSopOut, msgEopOut, msgTypeOut,
             msgByteIdxOut, msgLostOut, truncErrOut, lenErrOut},
            32'd0);
        chk("r_async_cnt", msgCntOut, 32'd0);
        step(1'b0, 8'h00, 1'b0);
        rstN = 1'b1;
        sendChk("r2_lh", 8'h00, 1'b0, 1'b0, 1'b0);
        sendChk("r2_ll", 8'h01, 1'b0, 1'b0, 1'b0);
        sendChk("r2_b0", 8'h44, 1'b1, 1'b1, 1'b1);
        chk("r2_type", {24'd0, msgTypeOut}, 32'h44);
        chk("r2_cnt", msgCntOut, 32'd1);
        idles("r2_gap", 5, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/itch_msg_framer.md
Name: itch_msg_framer

Overview:
- Sequences the ITCH byte stream that follows the MoldUDP64 header into discrete ITCH messages.
- Walks each message block's 2-byte big-endian length prefix, then emits payload bytes with SOP/EOP, message type, byte index and error flags.
- Sits directly downstream of the Ethernet/UDP parser (itchDataValid/itchData/packetLost outputs) and upstream of the order-book message decoder.
- Frame boundaries are inferred from an idle gap on the valid strobe.

Parameters:
- MAX_MSG_LEN, 64: largest legal ITCH message length in bytes; larger length prefixes are errors.
- GAP_CYCLES, 4: consecutive cycles with valid low that mark end of frame; range 2..15.

Ports:
- clkIn  in  1  single clock, same domain as the parser.
- rstNIn  in  1  asynchronous, active-low reset.
- itchDataValidIn  in  1  byte strobe from the parser.
- itchDataIn  in  8  ITCH byte.
- packetLostIn  in  1  one-cycle pulse from the parser: MoldUDP64 sequence gap on the current frame.
- msgValidOut  out  1  payload byte valid.
- msgDataOut  out  8  payload byte.
- msgSopOut  out  1  first byte of a message.
- msgEopOut  out  1  last byte of a message.
- msgTypeOut  out  8  ITCH message type (payload byte 0); held from SOP until the next SOP.
- msgByteIdxOut  out  6  index of the current byte within its message.
- msgLostOut  out  1  current frame follows a sequence gap; qualifies every msgValidOut.
- truncErrOut  out  1  one-cycle pulse: frame ended inside a length prefix or payload.
- lenErrOut  out  1  one-cycle pulse: length prefix greater than MAX_MSG_LEN.
- msgCntOut  out  32  count of completed messages, wraps.

Behaviour:
- All outputs are registered. Reset value is 0 for every output; msgTypeOut also resets to 0.
- Latency is exactly 1 cycle from an input byte to msgDataOut/msgValidOut.
- Reset is asynchronous: asserting it mid-message clears the state machine, counters and flags immediately. The first valid byte after release is treated as LEN_HI.
- State machine: LEN_HI, LEN_LO, PAYLOAD, DRAIN. Reset state is LEN_HI.
  - LEN_HI: on a valid byte, lenR[15:8] <= byte; go to LEN_LO.
  - LEN_LO: on a valid byte, form the length L = {lenR[15:8], byte}.
    - L == 0: no output; return to LEN_HI.
    - L > MAX_MSG_LEN: pulse lenErrOut; go to DRAIN.
    - Otherwise: remR <= L; idxR <= 0; go to PAYLOAD.
  - PAYLOAD: on each valid byte, emit it.
    - msgSopOut when idxR == 0; msgTypeOut captured from that byte.
    - msgEopOut when remR == 1; msgCntOut increments; go to LEN_HI.
    - remR decrements and idxR increments on each valid byte.
  - DRAIN: discard all bytes until frame end.
- A message of length 1 asserts SOP and EOP on the same byte.
- Valid bubbles shorter than GAP_CYCLES inside a frame are tolerated; state and counters hold.
- Gap counter: 4-bit. Cleared on a valid byte, incremented while valid is low, saturating at GAP_CYCLES. A frame-end event fires only on the cycle it reaches GAP_CYCLES.
- At frame end:
  - State LEN_LO or PAYLOAD: pulse truncErrOut; no EOP is issued; msgCntOut is unchanged.
  - Any state: go to LEN_HI; clear lostR.
  - Frame end in LEN_HI is normal and produces no error.
- Loss flag: packetLostIn sets lostR; msgLostOut = lostR registered alongside the data. If packetLostIn and frame end occur in the same cycle, the set wins (the pulse belongs to the new frame).
- Width rules: the length is a full 16-bit compare against MAX_MSG_LEN. remR and idxR are 6 bits, sized by MAX_MSG_LEN. msgCntOut wraps from 0xFFFFFFFF to 0.

Decomposition:
- pkg gets:
  - typedef enum itchFramerStateType {LEN_HI, LEN_LO, PAYLOAD, DRAIN};
  - ITCH_MAX_MSG_LEN = 64 (default for MAX_MSG_LEN);
  - ITCH_FRAME_GAP = 4.
- Sub-module frame_gap_detect holds the gap counter and produces a one-cycle frameEnd pulse. It is reusable by other stream consumers.

Test Plan:
- Two messages: bytes 00 03 41 10 20, 00 02 45 99, then 4 idle cycles -> SOP on 0x41 and 0x45; EOP on 0x20 and 0x99; msgTypeOut 0x41 then 0x45; msgCntOut = 2; no error pulses.
- Truncation: 00 05 41 01 02, then 4 idle cycles -> three bytes out, SOP only, no EOP; truncErrOut pulses once; msgCntOut unchanged. The next frame 00 01 53 gives SOP and EOP together on 0x53.
- Oversize length: 01 00 followed by 10 bytes -> lenErrOut pulses on the cycle after the 0x00 byte; no msgValidOut until the gap; the next frame parses normally.
- Zero length and bubbles: 00 00 00 02 41 [2 idle cycles] 42 -> zero-length block skipped; message 41 42 emitted with SOP/EOP; no truncErrOut.
- Loss flag: packetLostIn pulse, then 00 01 41, gap, then 00 01 42 -> msgLostOut = 1 with 0x41 and 0 with 0x42. A pulse coincident with frame end sets the flag for the following frame.
- Reset: assert rstNIn low mid-PAYLOAD -> all outputs 0 with no clock edge; after release, 00 01 44 gives SOP/EOP on 0x44 and msgCntOut = 1.
